// File: rtl/merge_rr.sv
// N-master to 1-slave merger with round-robin arbitration and a registered grant.
// The grant is held for a whole transaction; the slave response returns only to the granted master.
module merge_rr #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int N_MASTERS = 2,
    localparam int REQ_W    = 1 + ADDR_W + DATA_W + DATA_W / 8,
    localparam int RESP_W   = DATA_W + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_MASTERS*REQ_W-1:0]  m_req,
    output logic [N_MASTERS*RESP_W-1:0] m_resp,
    output logic [REQ_W-1:0]            s_req,
    input  logic [RESP_W-1:0]           s_resp
);

    localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        ptr_q, ptr_d;
    logic [N_MASTERS-1:0] m_valid;
    logic                 hit_found;
    logic [GW-1:0]        hit_idx;
    logic                 grant_valid;
    logic                 s_ready;

    // Index wrap is explicit so non-power-of-two N_MASTERS never yields an index >= N_MASTERS.
    function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_MASTERS) sum = sum - N_MASTERS;
        return GW'(sum);
    endfunction

    assign s_ready     = s_resp[0];
    assign grant_valid = m_valid[grant_q];

    always_comb begin
        for (int i = 0; i < N_MASTERS; i++) begin
            m_valid[i] = m_req[i*REQ_W + REQ_W - 1];
        end
    end

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (!hit_found && m_valid[wrap_add(ptr_q, i)]) begin
                hit_found = 1'b1;
                hit_idx   = wrap_add(ptr_q, i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (hit_found) begin
                    grant_d = hit_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Completion and abort (granted master drops valid) both release the bus.
                if (s_ready || !grant_valid) begin
                    state_d = IDLE;
                    ptr_d   = wrap_add(grant_q, 1);
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Outputs follow the registered state, so asynchronous reset zeroes them without a clock edge.
    always_comb begin
        s_req  = '0;
        m_resp = '0;
        if (state_q == BUSY) begin
            s_req                                  = m_req[int'(grant_q)*REQ_W +: REQ_W];
            m_resp[int'(grant_q)*RESP_W +: RESP_W] = s_resp;
        end
    end

endmodule

// File: tb/tb_merge_rr.sv
// Self-checking bench for merge_rr: N=2, N=3 and N=1 instances driven from one sequence,
// with a grant-order scoreboard and a simple slave responder.
module tb_merge_rr;

    localparam int DW     = 32;
    localparam int AW     = 32;
    localparam int REQ_W  = 1 + AW + DW + DW / 8;
    localparam int RESP_W = DW + 1;

    logic clk;
    logic rst;

    logic [2*REQ_W-1:0]  a_m_req;
    logic [2*RESP_W-1:0] a_m_resp;
    logic [REQ_W-1:0]    a_s_req;
    logic [RESP_W-1:0]   a_s_resp;

    logic [3*REQ_W-1:0]  b_m_req;
    logic [3*RESP_W-1:0] b_m_resp;
    logic [REQ_W-1:0]    b_s_req;
    logic [RESP_W-1:0]   b_s_resp;

    logic [REQ_W-1:0]    c_m_req;
    logic [RESP_W-1:0]   c_m_resp;
    logic [REQ_W-1:0]    c_s_req;
    logic [RESP_W-1:0]   c_s_resp;

    int n_checks;
    int n_fail;
    int a_q[$];
    int b_q[$];
    int b_cnt[3];

    merge_rr #(.DATA_W(DW), .ADDR_W(AW), .N_MASTERS(2)) dut_a (
        .clk(clk), .rst(rst), .m_req(a_m_req), .m_resp(a_m_resp), .s_req(a_s_req), .s_resp(a_s_resp)
    );
    merge_rr #(.DATA_W(DW), .ADDR_W(AW), .N_MASTERS(3)) dut_b (
        .clk(clk), .rst(rst), .m_req(b_m_req), .m_resp(b_m_resp), .s_req(b_s_req), .s_resp(b_s_resp)
    );
    merge_rr #(.DATA_W(DW), .ADDR_W(AW), .N_MASTERS(1)) dut_c (
        .clk(clk), .rst(rst), .m_req(c_m_req), .m_resp(c_m_resp), .s_req(c_s_req), .s_resp(c_s_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [REQ_W-1:0] mk_req(input logic v, input logic [AW-1:0] addr,
                                                 input logic [DW-1:0] wdata, input logic [DW/8-1:0] wstrb);
        return {v, addr, wdata, wstrb};
    endfunction

    // Slave for dut_a: ready one cycle after s_req turns valid; grant order checked against a_q.
    task automatic run_a(input int n_tx, input int budget);
        int busy = 0;
        int done = 0;
        int cyc  = 0;
        int id   = 0;
        logic gap = 1'b0;
        logic [2*RESP_W-1:0] exp_resp;
        while (done < n_tx && cyc < budget) begin
            @(negedge clk);
            cyc++;
            a_s_resp = '0;
            if (gap) begin
                check("a_idle_gap", a_s_req[REQ_W-1], 1'b0);
                gap = 1'b0;
            end else if (a_s_req[REQ_W-1]) begin
                if (busy == 0) begin
                    if (a_q.size() == 0) check("a_unexpected_grant", a_q.size(), 1);
                    else id = a_q.pop_front();
                    check("a_sreq", a_s_req, a_m_req[id*REQ_W +: REQ_W]);
                end
                busy++;
                if (busy == 2) begin
                    a_s_resp = {32'(32'hA000_0000 + done), 1'b1};
                    #1;
                    exp_resp = '0;
                    exp_resp[id*RESP_W +: RESP_W] = a_s_resp;
                    check("a_mresp", a_m_resp, exp_resp);
                    busy = 0;
                    done++;
                    gap  = 1'b1;
                end
            end
        end
        if (done < n_tx) check("a_timeout", done, n_tx);
    endtask

    task automatic run_b(input int n_tx, input int budget);
        int busy = 0;
        int done = 0;
        int cyc  = 0;
        int id   = 0;
        logic gap = 1'b0;
        logic [3*RESP_W-1:0] exp_resp;
        while (done < n_tx && cyc < budget) begin
            @(negedge clk);
            cyc++;
            b_s_resp = '0;
            if (gap) begin
                check("b_idle_gap", b_s_req[REQ_W-1], 1'b0);
                gap = 1'b0;
            end else if (b_s_req[REQ_W-1]) begin
                if (busy == 0) begin
                    if (b_q.size() == 0) check("b_unexpected_grant", b_q.size(), 1);
                    else id = b_q.pop_front();
                    b_cnt[id]++;
                    check("b_sreq", b_s_req, b_m_req[id*REQ_W +: REQ_W]);
                end
                busy++;
                if (busy == 2) begin
                    b_s_resp = {32'(32'hB000_0000 + done), 1'b1};
                    #1;
                    exp_resp = '0;
                    exp_resp[id*RESP_W +: RESP_W] = b_s_resp;
                    check("b_mresp", b_m_resp, exp_resp);
                    busy = 0;
                    done++;
                    gap  = 1'b1;
                end
            end
        end
        if (done < n_tx) check("b_timeout", done, n_tx);
    endtask

    logic [REQ_W-1:0]    a_w0, a_w1, c_wa, c_wb;
    logic [2*RESP_W-1:0] a_exp;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        a_w0 = mk_req(1'b1, 32'h0000_0020, 32'h0, 4'h0);
        a_w1 = mk_req(1'b1, 32'h0000_0010, 32'h0, 4'h0);
        c_wa = mk_req(1'b1, 32'h0000_0040, 32'h1111_1111, 4'hF);
        c_wb = mk_req(1'b1, 32'h0000_0044, 32'h2222_2222, 4'h3);
        rst      = 1'b0;
        a_m_req  = '0; a_s_resp = '0;
        b_m_req  = '0; b_s_resp = '0;
        c_m_req  = '0; c_s_resp = '0;

        // Reset state, held even with valid requests and ready present.
        @(negedge clk);
        check("rst_a_sreq", a_s_req, '0);
        check("rst_a_mresp", a_m_resp, '0);
        check("rst_b_sreq", b_s_req, '0);
        check("rst_c_mresp", c_m_resp, '0);
        a_m_req  = {a_w1, a_w0};
        a_s_resp = {32'hFFFF_FFFF, 1'b1};
        @(negedge clk);
        check("rst_hold_sreq", a_s_req, '0);
        check("rst_hold_mresp", a_m_resp, '0);
        a_m_req  = '0;
        a_s_resp = '0;
        rst      = 1'b1;

        // Single master: m1 read, ready on the second BUSY cycle.
        @(negedge clk);
        a_m_req = {a_w1, {REQ_W{1'b0}}};
        @(negedge clk);
        check("single_sreq_c1", a_s_req, a_w1);
        check("single_mresp_c1", a_m_resp, '0);
        @(negedge clk);
        check("single_sreq_c2", a_s_req, a_w1);
        a_s_resp = {32'hDEAD_BEEF, 1'b1};
        #1;
        check("single_mresp_done", a_m_resp, {32'hDEAD_BEEF, 1'b1, {RESP_W{1'b0}}});
        @(negedge clk);
        a_m_req = '0;
        check("single_idle_sreq", a_s_req, '0);
        check("single_ptr", dut_a.ptr_q, 0);
        a_s_resp = {32'h1234_5678, 1'b1};
        #1;
        check("idle_ready_ignored", a_m_resp, '0);
        @(negedge clk);
        a_s_resp = '0;
        check("idle_ready_stays_idle", a_s_req, '0);

        // Contention: both valid, grant order 0,1,0.
        a_m_req = {a_w1, a_w0};
        a_q.push_back(0);
        a_q.push_back(1);
        a_q.push_back(0);
        run_a(3, 40);

        // Abort: m0 granted, drops valid before ready; pending m1 follows.
        @(negedge clk);
        a_s_resp = '0;
        a_m_req  = {{REQ_W{1'b0}}, a_w0};
        check("abort_idle", a_s_req, '0);
        @(negedge clk);
        check("abort_grant0", a_s_req, a_w0);
        a_m_req = {a_w1, mk_req(1'b0, 32'h0000_0020, 32'h0, 4'h0)};
        #1;
        check("abort_verbatim", a_s_req, mk_req(1'b0, 32'h0000_0020, 32'h0, 4'h0));
        check("abort_no_resp", a_m_resp, '0);
        @(negedge clk);
        check("abort_sreq_zero", a_s_req, '0);
        check("abort_mresp_zero", a_m_resp, '0);
        check("abort_ptr", dut_a.ptr_q, 1);
        @(negedge clk);
        check("abort_then_m1", a_s_req, a_w1);
        a_s_resp = {32'h0BAD_F00D, 1'b1};
        #1;
        check("abort_m1_resp", a_m_resp, {32'h0BAD_F00D, 1'b1, {RESP_W{1'b0}}});

        // Reset while BUSY with grant=1.
        @(negedge clk);
        a_s_resp = '0;
        a_m_req  = {a_w1, {REQ_W{1'b0}}};
        @(negedge clk);
        check("mid_rst_busy", a_s_req, a_w1);
        a_s_resp = {32'h55AA_55AA, 1'b0};
        #1;
        a_exp = '0;
        a_exp[RESP_W +: RESP_W] = {32'h55AA_55AA, 1'b0};
        check("mid_rst_resp_routed", a_m_resp, a_exp);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_sreq_async", a_s_req, '0);
        check("mid_rst_mresp_async", a_m_resp, '0);
        @(negedge clk);
        a_s_resp = '0;
        a_m_req  = {a_w1, a_w0};
        @(negedge clk);
        check("mid_rst_ptr", dut_a.ptr_q, 0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_m0_first", a_s_req, a_w0);
        a_s_resp = {32'hCAFE_0000, 1'b1};
        @(negedge clk);
        a_s_resp = '0;
        a_m_req  = '0;

        // Fairness: three always-valid masters, 30 transactions.
        for (int i = 0; i < 3; i++) begin
            b_m_req[i*REQ_W +: REQ_W] = mk_req(1'b1, 32'(32'h100 * (i + 1)), 32'(32'hC0DE_0000 + i), 4'hF);
            b_cnt[i] = 0;
        end
        for (int t = 0; t < 30; t++) b_q.push_back(t % 3);
        run_b(30, 200);
        for (int i = 0; i < 3; i++) check($sformatf("b_count_m%0d", i), b_cnt[i], 10);
        @(negedge clk);
        b_m_req  = '0;
        b_s_resp = '0;

        // Single master instance: back-to-back writes with one IDLE cycle between.
        c_m_req = c_wa;
        @(negedge clk);
        check("deg_sreq_a", c_s_req, c_wa);
        c_s_resp = {32'h0, 1'b1};
        #1;
        check("deg_resp_a", c_m_resp, {32'h0, 1'b1});
        @(negedge clk);
        c_s_resp = '0;
        check("deg_idle_gap", c_s_req, '0);
        c_m_req = c_wb;
        @(negedge clk);
        check("deg_sreq_b", c_s_req, c_wb);
        c_s_resp = {32'h0, 1'b1};
        #1;
        check("deg_resp_b", c_m_resp, {32'h0, 1'b1});
        @(negedge clk);
        c_s_resp = '0;
        c_m_req  = '0;
        check("deg_idle_after", c_s_req, '0);
        check("deg_grant", dut_c.grant_q, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/merge_rr.md
Name: merge_rr

Overview:
- N-master to 1-slave merger for the native interconnect.
- Sits directly upstream of the address-decoding splitter: several masters share one slave-side bus that then feeds the splitter.
- Uses round-robin arbitration with a registered grant. The grant is held for a whole transaction, and the slave response is routed back only to the granted master.

Parameters:
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- ADDR_W, 32, address width.
- N_MASTERS, 2, number of masters; legal range 1..16.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- m_req  input  N_MASTERS*REQ_W  master requests; master i occupies bits [i*REQ_W +: REQ_W].
- m_resp  output  N_MASTERS*RESP_W  master responses; master i occupies [i*RESP_W +: RESP_W].
- s_req  output  REQ_W  merged request to downstream splitter/slave.
- s_resp  input  RESP_W  response from downstream.

Packing:
- REQ_W = 1+ADDR_W+DATA_W+DATA_W/8. Request word is {valid, addr, wdata, wstrb}, valid at MSB.
- RESP_W = DATA_W+1. Response word is {rdata, ready}, ready at LSB.

Behaviour:
- Grant index width GW = $clog2(N_MASTERS), minimum 1.
- State:
  - FSM state: IDLE or BUSY.
  - grant[GW-1:0]: the granted master.
  - ptr[GW-1:0]: highest-priority master for the next arbitration.
- Reset (rst=0, asynchronous): state=IDLE, grant=0, ptr=0.
  - s_req is all-zero.
  - Every m_resp slice is all-zero.
  - These hold for as long as rst=0.
- Arbitration happens only in IDLE.
  - Candidates are masters with valid=1.
  - Search order is ptr, ptr+1, ... wrapping at N_MASTERS-1 to 0.
  - First hit: grant <= hit, state <= BUSY on the next edge.
  - No candidate: stay IDLE; grant and ptr unchanged.
- Outputs are combinational from registered grant/state.
  - BUSY: s_req = m_req slice of grant, passed verbatim including valid.
  - IDLE: s_req = 0.
  - BUSY: m_resp slice of grant = s_resp; all other slices = 0.
  - IDLE: all m_resp slices = 0.
- Latency: a request arriving at edge k appears on s_req after edge k+1, i.e. one cycle of arbitration latency.
- Completion: in BUSY with s_resp ready=1 at a rising edge:
  - state <= IDLE, ptr <= grant+1, wrapping to 0 after N_MASTERS-1.
  - The ready cycle itself is delivered to the granted master.
- Minimum one IDLE cycle between consecutive grants, so the throughput bound is one transaction per 2 cycles plus slave latency.
- Abort: in BUSY, if the granted master's valid=0 and s_resp ready=0 at an edge:
  - state <= IDLE, ptr <= grant+1.
  - Nothing is delivered to any master.
- Simultaneous ready=1 and valid drop: treated as completion; same next state as abort.
- s_resp ready=1 while IDLE is ignored and not routed.
- Requests from non-granted masters are held off: they see ready=0 until granted and must keep valid asserted.
- N_MASTERS=1: ptr and grant stay 0. Behaviour reduces to a one-cycle registered gate: IDLE→BUSY→IDLE per transaction.
- Non-power-of-two N_MASTERS: ptr and grant never take values ≥ N_MASTERS; wrap is explicit, not modulo 2^GW.
- Reset mid-transaction: outputs zero immediately (asynchronous), state returns to IDLE. After release, arbitration restarts from master 0.

Test Plan:
- Single master: N=2, master1 read at addr 0x10; slave returns ready=1, rdata=0xDEADBEEF after 2 BUSY cycles.
  - s_req = m1 request from cycle 1.
  - m_resp1 = {0xDEADBEEF, 1} on the completion cycle; m_resp0 = 0 throughout.
  - Then IDLE, ptr=0.
- Contention: N=2, both masters valid at cycle 0, slave ready after 1 cycle.
  - Grant order is m0, then m1 after one IDLE cycle, then m0 again if still valid.
  - ptr sequence 0→1→0.
- Fairness: N=3, all masters continuously valid, slave always ready one cycle after s_req valid.
  - Over 30 transactions each master is granted exactly 10 times, in order 0,1,2,0,...
  - No master waits more than 2 grants.
- Abort: m0 granted, drops valid before ready.
  - Next cycle is IDLE, ptr=1, s_req=0.
  - A pending m1 is granted on the following edge.
- Reset mid-transaction: assert rst=0 while BUSY with grant=1.
  - s_req and m_resp go 0 without a clock edge.
  - After release with both valid, m0 is granted first.
- Degenerate: N_MASTERS=1 with writes at wstrb=0xF and 0x3 back-to-back.
  - Each is forwarded verbatim one cycle after valid.
  - Ready is returned to m0; there is exactly one IDLE cycle between them.
